// File: rtl/ysyx_mem_pkg.sv
// Shared types and defaults for the NPC memory-port arbiter.
package ysyx_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Transaction phase of the shared memory port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Requester identity, used for both the owner and last_grant registers.
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // Reads never carry byte enables to memory.
  function automatic logic [DATA_W_DEF/8-1:0] read_safe_mask(input logic                    wen,
                                                             input logic [DATA_W_DEF/8-1:0] mask);
    return wen ? mask : '0;
  endfunction

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Two-way round-robin grant between IFU and LSU with a last_grant register.
module ysyx_rr_arb2
  import ysyx_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req_ifu,
  input  logic i_req_lsu,
  input  logic i_take,
  output logic o_gnt_valid,
  output logic o_gnt_owner
);

  logic r_last_grant;

  // On a conflict the requester that was not granted last time wins.
  always_comb begin
    o_gnt_valid = i_req_ifu | i_req_lsu;
    o_gnt_owner = OWNER_IFU;
    if (i_req_ifu && i_req_lsu) begin
      o_gnt_owner = ~r_last_grant;
    end else if (i_req_lsu) begin
      o_gnt_owner = OWNER_LSU;
    end
  end

  // Remember the winner only when the grant is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= OWNER_IFU;
    end else if (i_take && o_gnt_valid) begin
      r_last_grant <= o_gnt_owner;
    end
  end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write);
// one transaction outstanding at a time.
module ysyx_mem_arbiter
  import ysyx_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_rsp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy,
  output logic              err_stray_rsp
);

  state_e            r_state;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_err;

  logic w_gnt_valid;
  logic w_gnt_owner;
  logic w_accept;
  logic w_rsp;

  assign w_accept = ~rst & (r_state == IDLE) & w_gnt_valid;
  assign w_rsp    = ~rst & (r_state == WAIT) & mem_rsp_valid;

  ysyx_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst         (rst),
    .i_req_ifu   (ifu_req_valid),
    .i_req_lsu   (lsu_req_valid),
    .i_take      (w_accept),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_owner (w_gnt_owner)
  );

  // Transaction FSM: latch the granted request, hold it to memory, await the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWNER_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_err   <= 1'b0;
    end else begin
      // A response with no request in flight is dropped but remembered.
      if (mem_rsp_valid && (r_state != WAIT)) begin
        r_err <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state <= REQ;
            r_owner <= w_gnt_owner;
            if (w_gnt_owner == OWNER_LSU) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wen ? lsu_wmask : '0;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even mid-transaction.
  always_comb begin
    ifu_req_ready = w_accept & (w_gnt_owner == OWNER_IFU);
    lsu_req_ready = w_accept & (w_gnt_owner == OWNER_LSU);
    ifu_rsp_valid = w_rsp & (r_owner == OWNER_IFU);
    lsu_rsp_valid = w_rsp & (r_owner == OWNER_LSU);
    ifu_rdata     = rst ? '0 : mem_rdata;
    lsu_rdata     = rst ? '0 : mem_rdata;
    mem_req_valid = ~rst & (r_state == REQ);
    mem_addr      = rst ? '0 : r_addr;
    mem_wen       = ~rst & r_wen;
    mem_wdata     = rst ? '0 : r_wdata;
    mem_wmask     = rst ? '0 : r_wmask;
    busy          = ~rst & (r_state != IDLE);
    err_stray_rsp = ~rst & r_err;
  end

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Randomised bench for ysyx_mem_arbiter against a transaction-level reference model.
module tb_ysyx_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        busy, err_stray_rsp;

  ysyx_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .err_stray_rsp (err_stray_rsp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: is a transaction open, has memory taken it yet, who owns it.
  bit        m_active, m_sent, m_owner, m_last, m_err;
  bit        m_wen;
  bit [31:0] m_addr, m_wdata;
  bit [3:0]  m_wmask;

  // Snapshot of DUT outputs at the last sample point.
  logic        s_ifu_ready, s_lsu_ready, s_ifu_rsp, s_lsu_rsp, s_mreq, s_mwen, s_busy, s_err;
  logic [31:0] s_ifu_rdata, s_lsu_rdata, s_maddr, s_mwdata;
  logic [3:0]  s_mwmask;
  int          q_gnt[$];

  // Called at posedge+1 with inputs already driven; samples at the falling edge.
  task automatic step();
    bit gv, g, e_rsp;
    #4;
    s_ifu_ready = ifu_req_ready; s_lsu_ready = lsu_req_ready;
    s_ifu_rsp   = ifu_rsp_valid; s_lsu_rsp   = lsu_rsp_valid;
    s_ifu_rdata = ifu_rdata;     s_lsu_rdata = lsu_rdata;
    s_mreq = mem_req_valid; s_maddr = mem_addr; s_mwen = mem_wen;
    s_mwdata = mem_wdata; s_mwmask = mem_wmask; s_busy = busy; s_err = err_stray_rsp;
    if (s_ifu_ready) q_gnt.push_back(0);
    if (s_lsu_ready) q_gnt.push_back(1);

    if (rst) begin
      check("rst_ifu_ready", s_ifu_ready, 0);
      check("rst_lsu_ready", s_lsu_ready, 0);
      check("rst_ifu_rsp", s_ifu_rsp, 0);
      check("rst_lsu_rsp", s_lsu_rsp, 0);
      check("rst_rdata", {s_ifu_rdata, s_lsu_rdata}, 0);
      check("rst_mem_out", {s_mreq, s_maddr, s_mwen, s_mwdata, s_mwmask}, 0);
      check("rst_busy_err", {s_busy, s_err}, 0);
      m_active = 0; m_sent = 0; m_last = 0; m_err = 0;
    end else begin
      gv = !m_active && (ifu_req_valid || lsu_req_valid);
      if (ifu_req_valid && lsu_req_valid) g = !m_last;
      else g = lsu_req_valid;
      e_rsp = m_active && m_sent && mem_rsp_valid;
      check("ifu_req_ready", s_ifu_ready, gv && !g);
      check("lsu_req_ready", s_lsu_ready, gv && g);
      check("ifu_rsp_valid", s_ifu_rsp, e_rsp && !m_owner);
      check("lsu_rsp_valid", s_lsu_rsp, e_rsp && m_owner);
      check("ifu_rdata", s_ifu_rdata, mem_rdata);
      check("lsu_rdata", s_lsu_rdata, mem_rdata);
      check("mem_req_valid", s_mreq, m_active && !m_sent);
      if (m_active && !m_sent)
        check("mem_payload", {s_maddr, s_mwen, s_mwdata, s_mwmask},
              {m_addr, m_wen, m_wdata, m_wmask});
      check("busy", s_busy, m_active);
      check("err_stray_rsp", s_err, m_err);

      if (mem_rsp_valid && !(m_active && m_sent)) m_err = 1;
      if (gv) begin
        m_active = 1; m_sent = 0; m_owner = g; m_last = g;
        if (g) begin
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata;
          m_wmask = lsu_wen ? lsu_wmask : 4'h0;
        end else begin
          m_addr = ifu_addr; m_wen = 0; m_wdata = 0; m_wmask = 0;
        end
      end else if (m_active && !m_sent) begin
        if (mem_req_ready) m_sent = 1;
      end else if (e_rsp) begin
        m_active = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; ifu_req_valid = 0; lsu_req_valid = 0; lsu_wen = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = $urandom;
  endtask

  initial begin
    rst = 1; ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rdata = 0;
    @(posedge clk); #1;

    // Reset state, with requests present that must not be accepted.
    ifu_req_valid = 1; lsu_req_valid = 1;
    step(); step();
    idle_inputs(); step();
    check("post_rst_busy", s_busy, 0);

    // IFU read alone.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; step();
    check("ifu_accept", s_ifu_ready, 1);
    ifu_req_valid = 0; mem_req_ready = 1; step();
    check("ifu_mem_addr", s_maddr, 32'h8000_0000);
    check("ifu_mem_wen_wmask", {s_mwen, s_mwmask}, 0);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0010_0073; step();
    check("ifu_rsp_pulse", {s_ifu_rsp, s_lsu_rsp}, 2'b10);
    check("ifu_rsp_data", s_ifu_rdata, 32'h0010_0073);
    idle_inputs(); step();
    check("ifu_rsp_once", s_ifu_rsp, 0);

    // LSU write with memory stalling for three cycles.
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; step();
    lsu_req_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3); step();
      check("lsu_wr_stable", {s_mreq, s_maddr, s_mwen, s_mwdata, s_mwmask},
            {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011});
    end
    mem_req_ready = 0; mem_rsp_valid = 1; step();
    check("lsu_wr_ack", {s_ifu_rsp, s_lsu_rsp}, 2'b01);
    idle_inputs(); step();

    // Conflicting requesters from a fresh reset alternate, LSU first.
    rst = 1; step(); idle_inputs();
    q_gnt.delete();
    for (int i = 0; i < 40; i++) begin
      ifu_req_valid = (q_gnt.size() < 4); lsu_req_valid = ifu_req_valid;
      ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 0;
      mem_req_ready = 1; mem_rsp_valid = m_active && m_sent; mem_rdata = $urandom;
      step();
    end
    check("gnt_count", q_gnt.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("gnt_order%0d", i), (i < q_gnt.size()) ? q_gnt[i] : 9, (i % 2 == 0) ? 1 : 0);
    idle_inputs();

    // LSU read masks off byte enables.
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wmask = 4'b1111; step();
    lsu_req_valid = 0; mem_req_ready = 1; step();
    check("lsu_rd_wmask", s_mwmask, 0);
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678; step();
    check("lsu_rd_data", {s_lsu_rsp, s_lsu_rdata}, {1'b1, 32'h1234_5678});
    idle_inputs(); step();

    // Reset while waiting for the response; a late response is then stray.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040; step();
    ifu_req_valid = 0; mem_req_ready = 1; step();
    mem_req_ready = 0; step();
    check("wait_busy", s_busy, 1);
    rst = 1; step();
    rst = 0; step();
    check("rst_wait_busy", {s_busy, s_ifu_rsp}, 0);
    mem_rsp_valid = 1; step();
    check("stray_not_fwd", {s_ifu_rsp, s_lsu_rsp, s_err}, 0);
    mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stray_sticky", s_err, 1);
    end
    rst = 1; step();
    rst = 0; step();
    check("stray_cleared", s_err, 0);

    // Randomised traffic with stalls, stray responses, drops and resets.
    for (int i = 0; i < 3000; i++) begin
      if (s_ifu_ready || (ifu_req_valid && $urandom_range(15) == 0)) ifu_req_valid = 0;
      if (s_lsu_ready || (lsu_req_valid && $urandom_range(15) == 0)) lsu_req_valid = 0;
      if (!ifu_req_valid && $urandom_range(2) == 0) begin
        ifu_req_valid = 1; ifu_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(2) == 0) begin
        lsu_req_valid = 1; lsu_addr = $urandom; lsu_wen = $urandom_range(1);
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(15));
      end
      mem_req_ready = $urandom_range(1);
      mem_rsp_valid = (m_active && m_sent) ? ($urandom_range(1) == 1) : ($urandom_range(63) == 0);
      mem_rdata = $urandom;
      rst = ($urandom_range(199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
